// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller and its LFSR.
package game_pkg;

    // Session sequencer states.
    typedef enum logic [3:0] {
        IDLE,
        GEN,
        RST_GAME,
        LOAD,
        START,
        WAIT,
        NEXT,
        DONE,
        FAIL,
        ABORT
    } state_t;

    // Notes per pattern word; each note occupies one 4-bit nibble.
    localparam int SLOTS = 8;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1: bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Seed used at reset and whenever a zero seed is requested.
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // A zero note means "silent" to the game module, so it is never emitted.
    localparam logic [2:0] NOTE_SILENT   = 3'd0;
    localparam logic [2:0] NOTE_FALLBACK = 3'd1;

    // One LFSR step: shift left, XOR of the taps enters at bit 0.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

    // Map the low LFSR bits to a playable note.
    function automatic logic [2:0] note_of(input logic [2:0] bits);
        return (bits == NOTE_SILENT) ? NOTE_FALLBACK : bits;
    endfunction

endpackage

// File: rtl/note_lfsr.sv
// 16-bit Fibonacci LFSR producing non-silent 3-bit notes.
// The note output is the note that belongs to the value after this cycle's step.
module note_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] FALLBACK_SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [2:0]  note
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = lfsr_advance(lfsr);
    assign note      = note_of(lfsr_next[2:0]);

    // LFSR register: reload on load (zero seed would lock up), otherwise step on demand.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            lfsr <= FALLBACK_SEED;
        end else if (load) begin
            lfsr <= (seed == 16'd0) ? FALLBACK_SEED : seed;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Multi-round session sequencer for the note-memory game module.
// Per round: build an 8-note pattern, reset the game, load the pattern,
// start it, then wait for game_end. All outputs decode the state register.
module game_round_controller
    import game_pkg::*;
#(
    parameter int          NUM_ROUNDS     = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd600_000_000,
    parameter logic [15:0] DEFAULT_SEED   = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        abort_btn,
    input  logic [15:0] seed,
    input  logic        game_end_in,
    output logic        game_reset_out,
    output logic        write_enable_out,
    output logic [31:0] data_out,
    output logic        game_start_out,
    output logic [2:0]  round_out,
    output logic        busy,
    output logic        all_done,
    output logic        timeout_flag
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  slot;
    logic [2:0]  round;
    logic [31:0] pattern;
    logic [31:0] timeout_cnt;
    logic        game_end_prev;
    logic        game_end_rise;
    logic        timeout_hit;
    logic        start_ok;
    logic        gen_step;
    logic [2:0]  note;

    // A start is only honoured from a resting state, and abort always wins.
    assign start_ok = start_btn && !abort_btn
                      && (state == IDLE || state == DONE || state == FAIL);

    assign gen_step      = (state == GEN);
    assign game_end_rise = game_end_in && !game_end_prev;
    assign timeout_hit   = (TIMEOUT_CYCLES != 32'd0)
                           && (timeout_cnt == TIMEOUT_CYCLES - 32'd1);

    note_lfsr #(
        .FALLBACK_SEED(DEFAULT_SEED)
    ) u_note_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok),
        .step  (gen_step),
        .seed  (seed),
        .note  (note)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next       = state;
        game_reset_out   = 1'b0;
        write_enable_out = 1'b0;
        data_out         = 32'd0;
        game_start_out   = 1'b0;
        busy             = 1'b1;
        all_done         = 1'b0;
        timeout_flag     = 1'b0;
        round_out        = round;

        if (abort_btn && state != IDLE) begin
            state_next = ABORT;
        end else begin
            case (state)
                IDLE, DONE, FAIL: if (start_ok) state_next = GEN;
                GEN:              if (slot == 3'(SLOTS - 1)) state_next = RST_GAME;
                RST_GAME:         state_next = LOAD;
                LOAD:             state_next = START;
                START:            state_next = WAIT;
                WAIT: begin
                    if (game_end_rise)    state_next = NEXT;
                    else if (timeout_hit) state_next = FAIL;
                end
                NEXT:             state_next = (round == 3'(NUM_ROUNDS - 1)) ? DONE : GEN;
                ABORT:            state_next = IDLE;
                default:          state_next = IDLE;
            endcase
        end

        case (state)
            IDLE:     busy = 1'b0;
            DONE: begin
                busy     = 1'b0;
                all_done = 1'b1;
            end
            FAIL: begin
                busy         = 1'b0;
                timeout_flag = 1'b1;
            end
            RST_GAME, ABORT: game_reset_out = 1'b1;
            LOAD: begin
                write_enable_out = 1'b1;
                data_out         = pattern;
            end
            START:   game_start_out = 1'b1;
            default: ;
        endcase
    end

    // Pattern assembly: one nibble per GEN cycle, bit 3 of each nibble kept clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the pattern register is reset even though it is only observed in
        // LOAD, so a stale word can never leak out after a mid-session reset.
        if (reset) begin
            slot    <= 3'd0;
            pattern <= 32'd0;
        end else if (state == GEN) begin
            slot                        <= slot + 3'd1;
            pattern[{slot, 2'b00} +: 4] <= {1'b0, note};
        end else begin
            slot <= 3'd0;
        end
    end

    // Round index: cleared on an accepted start, advanced when NEXT loops back to GEN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round <= 3'd0;
        end else if (start_ok) begin
            round <= 3'd0;
        end else if (state == NEXT && state_next == GEN) begin
            round <= round + 3'd1;
        end
    end

    // Saturating WAIT timer, cleared in START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= 32'd0;
        end else if (state == START) begin
            timeout_cnt <= 32'd0;
        end else if (state == WAIT && timeout_cnt != 32'hFFFF_FFFF) begin
            timeout_cnt <= timeout_cnt + 32'd1;
        end
    end

    // Previous game_end sample, tracked every cycle for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_end_prev <= 1'b0;
        end else begin
            game_end_prev <= game_end_in;
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller. Two instances share clock, reset,
// buttons and seed: u_dut (3 rounds, long timeout) and u_dut_to (1 round,
// 20-cycle timeout). Outputs are sampled on the falling clock edge.
module tb_game_round_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_btn;
    logic        abort_btn;
    logic [15:0] seed;
    logic        game_end_in;
    logic        game_end_to;

    logic        game_reset_out, write_enable_out, game_start_out;
    logic [31:0] data_out;
    logic [2:0]  round_out;
    logic        busy, all_done, timeout_flag;

    logic        to_game_reset_out, to_write_enable_out, to_game_start_out;
    logic [31:0] to_data_out;
    logic [2:0]  to_round_out;
    logic        to_busy, to_all_done, to_timeout_flag;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    game_round_controller #(
        .NUM_ROUNDS     (3),
        .TIMEOUT_CYCLES (32'd1000),
        .DEFAULT_SEED   (16'hACE1)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .start_btn        (start_btn),
        .abort_btn        (abort_btn),
        .seed             (seed),
        .game_end_in      (game_end_in),
        .game_reset_out   (game_reset_out),
        .write_enable_out (write_enable_out),
        .data_out         (data_out),
        .game_start_out   (game_start_out),
        .round_out        (round_out),
        .busy             (busy),
        .all_done         (all_done),
        .timeout_flag     (timeout_flag)
    );

    game_round_controller #(
        .NUM_ROUNDS     (1),
        .TIMEOUT_CYCLES (32'd20),
        .DEFAULT_SEED   (16'hACE1)
    ) u_dut_to (
        .clk              (clk),
        .reset            (reset),
        .start_btn        (start_btn),
        .abort_btn        (abort_btn),
        .seed             (seed),
        .game_end_in      (game_end_to),
        .game_reset_out   (to_game_reset_out),
        .write_enable_out (to_write_enable_out),
        .data_out         (to_data_out),
        .game_start_out   (to_game_start_out),
        .round_out        (to_round_out),
        .busy             (to_busy),
        .all_done         (to_all_done),
        .timeout_flag     (to_timeout_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        start_btn   = 1'b0;
        abort_btn   = 1'b0;
        game_end_in = 1'b0;
        game_end_to = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Start pulse over one cycle; returns at the first GEN cycle.
    task automatic pulse_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    // Bounded wait for the pattern-load strobe; returns the word on the bus.
    task automatic wait_we(output logic [31:0] word);
        for (int k = 0; k < 40 && !write_enable_out; k++) tick();
        check("we_seen", 32'(write_enable_out), 32'd1);
        word = data_out;
    endtask

    // Reference pattern generator, advancing the bench's own LFSR copy.
    task automatic model_next_word(output logic [31:0] word);
        logic [2:0] n;
        word = 32'd0;
        for (int s = 0; s < 8; s++) begin
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            n = m_lfsr[2:0];
            if (n == 3'd0) n = 3'd1;
            word[4*s +: 4] = {1'b0, n};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w0, w1, e;
        logic [31:0] words [3];
        logic        saw_a, saw_b;

        seed = 16'h0000;
        do_reset();

        // Reset state.
        check("rst_grst",  32'(game_reset_out),   32'd0);
        check("rst_we",    32'(write_enable_out), 32'd0);
        check("rst_data",  data_out,              32'd0);
        check("rst_gs",    32'(game_start_out),   32'd0);
        check("rst_round", 32'(round_out),        32'd0);
        check("rst_busy",  32'(busy),             32'd0);
        check("rst_done",  32'(all_done),         32'd0);
        check("rst_tof",   32'(timeout_flag),     32'd0);

        // Zero seed falls back to ACE1.
        seed = 16'h0000;
        pulse_start();
        wait_we(w0);
        m_lfsr = 16'hACE1;
        model_next_word(e);
        check("pat_seed0", w0, e);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("nib%0d_b3", i),   32'(w0[4*i+3]),          32'd0);
            check($sformatf("nib%0d_lonz", i), 32'(w0[4*i +: 3] != 0),  32'd1);
        end
        do_reset();
        seed = 16'hACE1;
        pulse_start();
        wait_we(w1);
        check("pat_seedace1", w1, w0);

        // Start-to-strobe latency, cycle by cycle.
        do_reset();
        seed = 16'h5A5A;
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("lat%0d_grst", k), 32'(game_reset_out),   32'(k == 9));
            check($sformatf("lat%0d_we", k),   32'(write_enable_out), 32'(k == 10));
            check($sformatf("lat%0d_gs", k),   32'(game_start_out),   32'(k == 11));
            check($sformatf("lat%0d_busy", k), 32'(busy),             32'd1);
            tick();
        end

        // Three full rounds with game_end 50 cycles after each game_start.
        do_reset();
        seed   = 16'h1234;
        m_lfsr = 16'h1234;
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            wait_we(words[r]);
            model_next_word(e);
            check($sformatf("round%0d_pat", r), words[r], e);
            check($sformatf("round%0d_idx", r), 32'(round_out), 32'(r));
            tick();
            check($sformatf("round%0d_gs", r), 32'(game_start_out), 32'd1);
            for (int k = 0; k < 50; k++) tick();
            game_end_in = 1'b1;
            tick();
            tick();
            tick();
            game_end_in = 1'b0;
        end
        for (int k = 0; k < 20 && !all_done; k++) tick();
        check("sess_done",  32'(all_done),  32'd1);
        check("sess_busy",  32'(busy),      32'd0);
        check("sess_round", 32'(round_out), 32'd2);
        check("distinct01", 32'(words[0] != words[1]), 32'd1);
        check("distinct12", 32'(words[1] != words[2]), 32'd1);
        check("distinct02", 32'(words[0] != words[2]), 32'd1);

        // Start and abort together in DONE: abort wins, back to IDLE.
        start_btn = 1'b1;
        abort_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        abort_btn = 1'b0;
        check("sa_grst", 32'(game_reset_out), 32'd1);
        check("sa_done", 32'(all_done),       32'd0);
        tick();
        check("sa_grst_off", 32'(game_reset_out), 32'd0);
        check("sa_idle",     32'(busy),           32'd0);
        saw_a = 1'b0;
        for (int k = 0; k < 12; k++) begin
            saw_a |= write_enable_out | busy;
            tick();
        end
        check("sa_stay_idle", 32'(saw_a), 32'd0);

        // Timeout: FAIL exactly 20 cycles after WAIT entry; a new start clears it.
        do_reset();
        pulse_start();
        for (int k = 0; k < 20 && !to_game_start_out; k++) tick();
        check("to_gs_seen", 32'(to_game_start_out), 32'd1);
        tick();
        for (int k = 0; k < 19; k++) tick();
        check("to_pre_flag", 32'(to_timeout_flag), 32'd0);
        check("to_pre_busy", 32'(to_busy),         32'd1);
        tick();
        check("to_flag", 32'(to_timeout_flag), 32'd1);
        check("to_busy", 32'(to_busy),         32'd0);
        pulse_start();
        check("to_clear",   32'(to_timeout_flag), 32'd0);
        check("to_restart", 32'(to_busy),         32'd1);

        // Abort during GEN slot 4.
        do_reset();
        pulse_start();
        for (int k = 0; k < 4; k++) tick();
        abort_btn = 1'b1;
        tick();
        abort_btn = 1'b0;
        check("ab_grst", 32'(game_reset_out), 32'd1);
        check("ab_busy", 32'(busy),           32'd1);
        tick();
        check("ab_grst_off", 32'(game_reset_out), 32'd0);
        check("ab_idle",     32'(busy),           32'd0);
        saw_a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            saw_a |= write_enable_out | game_start_out;
            tick();
        end
        check("ab_no_strobe", 32'(saw_a), 32'd0);

        // game_end already high entering WAIT is not an edge.
        do_reset();
        game_end_in = 1'b1;
        pulse_start();
        for (int k = 0; k < 20 && !game_start_out; k++) tick();
        check("ge_gs_seen", 32'(game_start_out), 32'd1);
        saw_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            saw_b |= game_reset_out;
        end
        check("ge_hold_grst",  32'(saw_b),     32'd0);
        check("ge_hold_round", 32'(round_out), 32'd0);
        check("ge_hold_busy",  32'(busy),      32'd1);
        game_end_in = 1'b0;
        tick();
        tick();
        game_end_in = 1'b1;
        for (int k = 0; k < 6 && round_out != 3'd1; k++) tick();
        check("ge_advance", 32'(round_out), 32'd1);
        game_end_in = 1'b0;

        // Async reset while in LOAD clears outputs without waiting for a clock.
        do_reset();
        pulse_start();
        wait_we(w0);
        #1 reset = 1'b1;
        #1;
        check("ar_we",    32'(write_enable_out), 32'd0);
        check("ar_data",  data_out,              32'd0);
        check("ar_grst",  32'(game_reset_out),   32'd0);
        check("ar_gs",    32'(game_start_out),   32'd0);
        check("ar_busy",  32'(busy),             32'd0);
        check("ar_round", 32'(round_out),        32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
